// File: rtl/systolic_feed_ctrl.sv
// Producer side of the systolic column-MAC feed: streams Wout-long feature loops per tile
// while preloading the next tile's TOUT weights. Optional macro: SYSTOLIC_FEED_PERF_EN (WAIT-cycle counter).
module systolic_feed_ctrl #(
    parameter int TOUT   = 8,
    parameter int DAT_W  = 128,
    parameter int WT_W   = 128,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 10,
    parameter int DRAIN  = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_wout,
    input  logic [CNT_W-1:0]         cfg_ntile,
    input  logic [ADDR_W-1:0]        cfg_dat_base,
    input  logic [ADDR_W-1:0]        cfg_wt_base,
    output logic                     busy,
    output logic                     done,
    output logic                     dat_rd_en,
    output logic [ADDR_W-1:0]        dat_rd_addr,
    input  logic [DAT_W-1:0]         dat_rd_data,
    output logic                     wt_rd_en,
    output logic [ADDR_W-1:0]        wt_rd_addr,
    input  logic [WT_W-1:0]          wt_rd_data,
    output logic                     dat_vld,
    output logic [DAT_W-1:0]         dat,
    output logic                     Wout_loop_start,
    output logic                     Wout_loop_end,
    output logic                     wt_vld,
    output logic [WT_W-1:0]          wt,
    output logic [$clog2(TOUT)-1:0]  wt_sel,
    output logic [15:0]              perf_stall_cnt
);
    localparam int SEL_W = $clog2(TOUT);
    localparam int DRW   = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_STREAM, S_WAIT, S_DRAIN, S_FIN} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    t_q, t_d, w_q, w_d, wout_q, wout_d, ntile_q, ntile_d;
    logic [SEL_W-1:0]    k_q, k_d;
    logic                pre_q, pre_d, rdy_q, rdy_d;
    logic [ADDR_W-1:0]   dat_addr_q, dat_addr_d, wt_addr_q, wt_addr_d;
    logic [DRW-1:0]      drain_q, drain_d;
    logic                dat_vld_q, ls_q, le_q, wt_vld_q;
    logic [SEL_W-1:0]    sel_q;

    logic loop_start, loop_end, last_tile, k_last, pre_ready;

    assign dat_rd_en  = (state_q == S_STREAM);
    assign wt_rd_en   = (state_q == S_WLOAD) || pre_q;
    assign loop_start = dat_rd_en && (w_q == '0);
    assign loop_end   = dat_rd_en && (w_q == wout_q - CNT_W'(1));
    assign last_tile  = (t_q == ntile_q - CNT_W'(1));
    assign k_last     = (k_q == SEL_W'(TOUT - 1));
    // Next loop may start once the preload's final read lands no later than its first dat read;
    // a loop-start cycle cannot qualify since the next tile's preload has not begun yet.
    assign pre_ready  = !loop_start && (rdy_q || (pre_q && k_q >= SEL_W'(TOUT - 2)));

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        w_d        = w_q;
        k_d        = k_q;
        pre_d      = pre_q;
        rdy_d      = rdy_q;
        wout_d     = wout_q;
        ntile_d    = ntile_q;
        dat_addr_d = dat_addr_q;
        wt_addr_d  = wt_addr_q;
        drain_d    = drain_q;

        if (wt_rd_en) begin
            wt_addr_d = wt_addr_q + ADDR_W'(1);
            k_d       = k_last ? '0 : k_q + SEL_W'(1);
        end
        if (pre_q && k_last) begin
            pre_d = 1'b0;
            rdy_d = 1'b1;
        end
        if (dat_rd_en) begin
            dat_addr_d = dat_addr_q + ADDR_W'(1);
            w_d        = loop_end ? '0 : w_q + CNT_W'(1);
        end
        // The staged tile is consumed here; preload of the following one starts next cycle.
        if (loop_start) begin
            pre_d = !last_tile;
            rdy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wout_d     = cfg_wout;
                    ntile_d    = cfg_ntile;
                    dat_addr_d = cfg_dat_base;
                    wt_addr_d  = cfg_wt_base;
                    t_d        = '0;
                    w_d        = '0;
                    k_d        = '0;
                    pre_d      = 1'b0;
                    rdy_d      = 1'b0;
                    state_d    = (cfg_wout == '0 || cfg_ntile == '0) ? S_FIN : S_WLOAD;
                end
            end
            S_WLOAD: if (k_last) state_d = S_STREAM;
            S_STREAM: begin
                if (loop_end) begin
                    if (last_tile) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        t_d     = t_q + CNT_W'(1);
                        state_d = pre_ready ? S_STREAM : S_WAIT;
                    end
                end
            end
            S_WAIT:  if (pre_ready) state_d = S_STREAM;
            S_DRAIN: begin
                drain_d = drain_q + DRW'(1);
                if (drain_q == DRW'(DRAIN - 1)) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            w_q        <= '0;
            k_q        <= '0;
            pre_q      <= 1'b0;
            rdy_q      <= 1'b0;
            wout_q     <= '0;
            ntile_q    <= '0;
            dat_addr_q <= '0;
            wt_addr_q  <= '0;
            drain_q    <= '0;
            dat_vld_q  <= 1'b0;
            ls_q       <= 1'b0;
            le_q       <= 1'b0;
            wt_vld_q   <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            w_q        <= w_d;
            k_q        <= k_d;
            pre_q      <= pre_d;
            rdy_q      <= rdy_d;
            wout_q     <= wout_d;
            ntile_q    <= ntile_d;
            dat_addr_q <= dat_addr_d;
            wt_addr_q  <= wt_addr_d;
            drain_q    <= drain_d;
            dat_vld_q  <= dat_rd_en;
            ls_q       <= loop_start;
            le_q       <= loop_end;
            wt_vld_q   <= wt_rd_en;
            sel_q      <= wt_rd_en ? k_q : '0;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FIN);
    assign dat_rd_addr     = dat_addr_q;
    assign wt_rd_addr      = wt_addr_q;
    assign dat_vld         = dat_vld_q;
    assign dat             = dat_vld_q ? dat_rd_data : '0;
    assign Wout_loop_start = ls_q;
    assign Wout_loop_end   = le_q;
    assign wt_vld          = wt_vld_q;
    assign wt              = wt_vld_q ? wt_rd_data : '0;
    assign wt_sel          = sel_q;

`ifdef SYSTOLIC_FEED_PERF_EN
    logic [15:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   perf_q <= '0;
        else if (state_q == S_IDLE && start)          perf_q <= '0;
        else if (state_q == S_WAIT && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
    end
    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: buffer models, beat monitor, immediate-assertion checks.
module tb_systolic_feed_ctrl;
    localparam int TOUT = 8, DAT_W = 128, WT_W = 128, ADDR_W = 12, CNT_W = 10;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
    logic [CNT_W-1:0]  cfg_wout = '0, cfg_ntile = '0;
    logic [ADDR_W-1:0] cfg_dat_base = '0, cfg_wt_base = '0;
    logic busy, done, dat_rd_en, wt_rd_en, dat_vld, ls, le, wt_vld;
    logic [ADDR_W-1:0] dat_rd_addr, wt_rd_addr;
    logic [DAT_W-1:0]  dat_rd_data = '0, dat;
    logic [WT_W-1:0]   wt_rd_data = '0, wt;
    logic [2:0]        wt_sel;
    logic [15:0]       perf;

    systolic_feed_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_wout(cfg_wout), .cfg_ntile(cfg_ntile),
        .cfg_dat_base(cfg_dat_base), .cfg_wt_base(cfg_wt_base),
        .busy(busy), .done(done),
        .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .dat_vld(dat_vld), .dat(dat), .Wout_loop_start(ls), .Wout_loop_end(le),
        .wt_vld(wt_vld), .wt(wt), .wt_sel(wt_sel), .perf_stall_cnt(perf)
    );

    always #5 clk = ~clk;

    function automatic logic [DAT_W-1:0] dword(input logic [ADDR_W-1:0] a);
        return {{(DAT_W-ADDR_W-4){1'b0}}, 4'hD, a};
    endfunction
    function automatic logic [WT_W-1:0] wword(input logic [ADDR_W-1:0] a);
        return {{(WT_W-ADDR_W-4){1'b0}}, 4'hB, a};
    endfunction

    always @(posedge clk) begin
        if (dat_rd_en) dat_rd_data <= dword(dat_rd_addr);
        if (wt_rd_en)  wt_rd_data  <= wword(wt_rd_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_wt, n_dat, n_ls, n_le, n_both, n_sel0, n_done, n_busy, n_rden;
    int bad_sel, bad_dat, bad_wt, bad_inv, first_dat, last_dat, first_wt, done_cyc, n_addr;
    logic [ADDR_W-1:0] exp_da, exp_wa;
    logic [2:0]        exp_sel;
    logic [ADDR_W-1:0] alog [4];

    always @(negedge clk) begin
        if (clr) begin
            n_wt = 0; n_dat = 0; n_ls = 0; n_le = 0; n_both = 0; n_sel0 = 0;
            n_done = 0; n_busy = 0; n_rden = 0; bad_sel = 0; bad_dat = 0; bad_wt = 0;
            bad_inv = 0; first_dat = -1; last_dat = -1; first_wt = -1; done_cyc = -1; n_addr = 0;
            exp_da = cfg_dat_base; exp_wa = cfg_wt_base; exp_sel = '0;
            for (int i = 0; i < 4; i++) alog[i] = '0;
        end else begin
            if (wt_vld) begin
                n_wt++;
                if (first_wt < 0) first_wt = cyc;
                if (wt_sel == 3'd0) n_sel0++;
                if (wt_sel !== exp_sel) bad_sel++;
                if (wt !== wword(exp_wa)) bad_wt++;
                exp_sel = exp_sel + 3'd1;
                exp_wa  = exp_wa + 12'd1;
            end
            if (dat_vld) begin
                n_dat++;
                if (first_dat < 0) first_dat = cyc;
                last_dat = cyc;
                if (dat !== dword(exp_da)) bad_dat++;
                exp_da = exp_da + 12'd1;
            end
            if (ls) n_ls++;
            if (le) n_le++;
            if (ls && le) n_both++;
            if (n_sel0 - n_ls < 0 || n_sel0 - n_ls > 1) bad_inv++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (busy) n_busy++;
            if (dat_rd_en || wt_rd_en) n_rden++;
            if (dat_rd_en && n_addr < 4) begin alog[n_addr] = dat_rd_addr; n_addr++; end
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_job(input int wout, input int ntile, input int dbase, input int wbase,
                           input bit extra_start, output int waited);
        logic tmo;
        @(posedge clk); #1;
        cfg_wout = CNT_W'(wout); cfg_ntile = CNT_W'(ntile);
        cfg_dat_base = ADDR_W'(dbase); cfg_wt_base = ADDR_W'(wbase);
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        waited = 0; tmo = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            waited++;
            if (done) begin tmo = 1'b0; break; end
            if (extra_start && waited == 5) begin
                #1 start = 1'b1; cfg_wout = 10'd2;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        check("job_timeout", 64'(tmo), 64'd0);
        @(posedge clk); #1;
        check("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    int w;
    int exp_perf;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_rd_en", 64'({dat_rd_en, wt_rd_en}), 64'd0);
        check("rst_strobes", 64'({dat_vld, ls, le, wt_vld, wt_sel}), 64'd0);
        check("rst_perf", 64'(perf), 64'd0);
        rst_n = 1'b1;

        // wout=16, ntile=3: steady-state overlap, no gaps
        run_job(16, 3, 'h100, 'h200, 1'b0, w);
        check("j1_wt_vld", 64'(n_wt), 64'd24);
        check("j1_dat_vld", 64'(n_dat), 64'd48);
        check("j1_starts", 64'(n_ls), 64'd3);
        check("j1_ends", 64'(n_le), 64'd3);
        check("j1_gaps", 64'(last_dat - first_dat + 1 - n_dat), 64'd0);
        check("j1_drain", 64'(done_cyc - last_dat), 64'd18);
        check("j1_sel_seq", 64'(bad_sel), 64'd0);
        check("j1_dat_data", 64'(bad_dat), 64'd0);
        check("j1_wt_data", 64'(bad_wt), 64'd0);
        check("j1_invariant", 64'(bad_inv), 64'd0);
        check("j1_done_once", 64'(n_done), 64'd1);
        check("j1_perf", 64'(perf), 64'd0);

        // wout=4, ntile=2: loop 2 waits on the preload
        run_job(4, 2, 'h010, 'h020, 1'b0, w);
`ifdef SYSTOLIC_FEED_PERF_EN
        exp_perf = 4;
`else
        exp_perf = 0;
`endif
        check("j2_dat_vld", 64'(n_dat), 64'd8);
        check("j2_wt_vld", 64'(n_wt), 64'd16);
        check("j2_gap", 64'(last_dat - first_dat + 1 - n_dat), 64'd4);
        check("j2_perf", 64'(perf), 64'(exp_perf));
        check("j2_invariant", 64'(bad_inv), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("j2_perf_hold", 64'(perf), 64'(exp_perf));

        // wout=1, ntile=1
        run_job(1, 1, 'h040, 'h050, 1'b0, w);
        check("j3_dat_vld", 64'(n_dat), 64'd1);
        check("j3_start_eq_end", 64'(n_both), 64'd1);
        check("j3_wt_vld", 64'(n_wt), 64'd8);
        check("j3_wt_first", 64'(first_wt < first_dat), 64'd1);
        check("j3_sel_seq", 64'(bad_sel), 64'd0);
        check("j3_perf_clr", 64'(perf), 64'd0);

        // zero configurations
        run_job(8, 0, 0, 0, 1'b0, w);
        check("z1_done_lat", 64'(w), 64'd1);
        check("z1_no_reads", 64'(n_rden), 64'd0);
        check("z1_busy_cycles", 64'(n_busy), 64'd1);
        run_job(0, 5, 0, 0, 1'b0, w);
        check("z2_done_lat", 64'(w), 64'd1);
        check("z2_no_reads", 64'(n_rden + n_dat + n_wt), 64'd0);

        // reset in the middle of a job
        @(posedge clk); #1;
        cfg_wout = 10'd8; cfg_ntile = 10'd2; cfg_dat_base = 12'h300; cfg_wt_base = 12'h400;
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("pre_rst_streaming", 64'(dat_rd_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy_done", 64'({busy, done}), 64'd0);
        check("mid_rst_outputs", 64'({dat_rd_en, wt_rd_en, dat_vld, wt_vld, ls, le}), 64'd0);
        @(posedge clk); #1;
        check("mid_rst_held", 64'({busy, dat_vld, wt_vld, wt_sel}), 64'd0);
        rst_n = 1'b1;
        run_job(8, 2, 'h300, 'h400, 1'b0, w);
        check("r_dat_vld", 64'(n_dat), 64'd16);
        check("r_wt_vld", 64'(n_wt), 64'd16);
        check("r_pairs", 64'({n_ls[7:0], n_le[7:0]}), 64'h0202);
        check("r_data", 64'(bad_dat + bad_wt + bad_sel + bad_inv), 64'd0);
        check("r_done_once", 64'(n_done), 64'd1);

        // address wrap plus a start pulse while busy
        run_job(4, 1, 'hFFE, 'hFFC, 1'b1, w);
        check("wrap_addr0", 64'(alog[0]), 64'h FFE);
        check("wrap_addr1", 64'(alog[1]), 64'h FFF);
        check("wrap_addr2", 64'(alog[2]), 64'h000);
        check("wrap_addr3", 64'(alog[3]), 64'h001);
        check("wrap_dat_vld", 64'(n_dat), 64'd4);
        check("wrap_data", 64'(bad_dat + bad_wt), 64'd0);
        check("wrap_invariant", 64'(bad_inv), 64'd0);
        check("wrap_done_once", 64'(n_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
